// File: rtl/panda_pulse_sched.sv
// panda_pulse_sched: sequences one pulse block through an armed pulse train.
// Loads DELAY/WIDTH when idle. Holds writes made during a train in shadow
// registers until the sequencer returns to idle. Issues COUNT single-cycle
// triggers PERIOD clocks apart, defers a due trigger while the block queue
// is too full, then waits for the block to drain. Flushes the block on
// ARM, on DISARM and on any block error.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   ARM/DISARM/CFG_WR strobes; CFG_DELAY/CFG_WIDTH/PERIOD/COUNT config
//   queue_i/out_i/perr_i/overflow_i   pulse block status
//   inp_o/DELAY_o/WIDTH_o/FORCE_RST_o pulse block controls
//   ACTIVE/DONE/ERR_ABORT/TRIG_CNT/STATE status (all registered)
module panda_pulse_sched #(
    parameter int unsigned QUEUE_HI = 1000,
    parameter int unsigned QW       = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ARM,
    input  logic          DISARM,
    input  logic          CFG_WR,
    input  logic [47:0]   CFG_DELAY,
    input  logic [47:0]   CFG_WIDTH,
    input  logic [31:0]   PERIOD,
    input  logic [31:0]   COUNT,
    input  logic [QW-1:0] queue_i,
    input  logic          out_i,
    input  logic          perr_i,
    input  logic          overflow_i,
    output logic          inp_o,
    output logic [47:0]   DELAY_o,
    output logic [47:0]   WIDTH_o,
    output logic          FORCE_RST_o,
    output logic          ACTIVE,
    output logic          DONE,
    output logic          ERR_ABORT,
    output logic [31:0]   TRIG_CNT,
    output logic [1:0]    STATE
);

    localparam int unsigned DW = 48;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [CW-1:0] trig_cnt_q, trig_cnt_d;
    logic          inp_q, inp_d;
    logic          force_q, force_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          active_q, active_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [DW-1:0] width_q, width_d;
    logic [DW-1:0] sh_delay_q, sh_delay_d;
    logic [DW-1:0] sh_width_q, sh_width_d;
    logic          sh_pend_q, sh_pend_d;

    logic blk_err;
    logic throttle;

    assign blk_err  = perr_i | overflow_i;
    assign throttle = (queue_i >= QW'(QUEUE_HI));

    // Next-state, pacing and configuration shadowing
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        count_d    = count_q;
        timer_d    = timer_q;
        trig_cnt_d = trig_cnt_q;
        inp_d      = 1'b0;
        force_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        delay_d    = delay_q;
        width_d    = width_q;
        sh_delay_d = sh_delay_q;
        sh_width_d = sh_width_q;
        sh_pend_d  = sh_pend_q;

        // Applied values only change while idle; a direct write beats a pending shadow
        if (state_q == ST_IDLE) begin
            if (CFG_WR) begin
                delay_d   = CFG_DELAY;
                width_d   = CFG_WIDTH;
                sh_pend_d = 1'b0;
            end else if (sh_pend_q) begin
                delay_d   = sh_delay_q;
                width_d   = sh_width_q;
                sh_pend_d = 1'b0;
            end
        end else if (CFG_WR) begin
            sh_delay_d = CFG_DELAY;
            sh_width_d = CFG_WIDTH;
            sh_pend_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ARM) begin
                    state_d    = ST_FLUSH;
                    trig_cnt_d = '0;
                    err_d      = 1'b0;
                    period_d   = (PERIOD < CW'(2)) ? CW'(2) : PERIOD;
                    count_d    = COUNT;
                    timer_d    = '0;
                end
            end
            ST_FLUSH: begin
                force_d = 1'b1;
                if (DISARM) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (DISARM) begin
                    force_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (blk_err) begin
                    force_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    // Timer stays at zero while throttled so the trigger fires on release
                    if (!throttle) begin
                        inp_d      = 1'b1;
                        trig_cnt_d = trig_cnt_q + CW'(1);
                        timer_d    = period_q - CW'(1);
                        if (trig_cnt_q + CW'(1) >= count_q) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end else begin
                    timer_d = timer_q - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (DISARM) begin
                    force_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (blk_err) begin
                    force_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if ((queue_i == '0) && !out_i) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        active_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            period_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            trig_cnt_q <= '0;
            inp_q      <= 1'b0;
            force_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
            delay_q    <= '0;
            width_q    <= '0;
            sh_delay_q <= '0;
            sh_width_q <= '0;
            sh_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            trig_cnt_q <= trig_cnt_d;
            inp_q      <= inp_d;
            force_q    <= force_d;
            done_q     <= done_d;
            err_q      <= err_d;
            active_q   <= active_d;
            delay_q    <= delay_d;
            width_q    <= width_d;
            sh_delay_q <= sh_delay_d;
            sh_width_q <= sh_width_d;
            sh_pend_q  <= sh_pend_d;
        end
    end

    assign inp_o       = inp_q;
    assign DELAY_o     = delay_q;
    assign WIDTH_o     = width_q;
    assign FORCE_RST_o = force_q;
    assign ACTIVE      = active_q;
    assign DONE        = done_q;
    assign ERR_ABORT   = err_q;
    assign TRIG_CNT    = trig_cnt_q;
    assign STATE       = state_q;

endmodule
